// File: rtl/mips_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit:
// access sizes, FSM encodings and data/byte-enable widths.
package mips_mem_lsu_pkg;

    localparam int MIPS_DATA_WIDTH = 32;
    localparam int MIPS_BE_WIDTH   = 4;

    localparam logic [1:0] MIPS_LSU_SIZE_B = 2'b00;
    localparam logic [1:0] MIPS_LSU_SIZE_H = 2'b01;
    localparam logic [1:0] MIPS_LSU_SIZE_W = 2'b10;
    localparam logic [1:0] MIPS_LSU_SIZE_X = 2'b11;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

endpackage

// File: rtl/mips_mem_lsu_align.sv
// Combinational lane logic: misalign check, store byte enables and
// data replication, load byte/half extract with sign/zero extension.
module mips_mem_lsu_align
    import mips_mem_lsu_pkg::*;
(
    input  logic [1:0]                 addr_lo,
    input  logic [1:0]                 size,
    input  logic                       usign,
    input  logic [MIPS_DATA_WIDTH-1:0] wdata,
    input  logic [MIPS_DATA_WIDTH-1:0] rsp,
    output logic                       misalign,
    output logic [MIPS_BE_WIDTH-1:0]   be,
    output logic [MIPS_DATA_WIDTH-1:0] wdata_rep,
    output logic [MIPS_DATA_WIDTH-1:0] rdata
);

    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic [7:0] b_sel;
    logic [15:0] h_sel;

    assign is_b = (size == MIPS_LSU_SIZE_B);
    assign is_h = (size == MIPS_LSU_SIZE_H);
    assign is_w = (size == MIPS_LSU_SIZE_W);

    always_comb begin
        b_sel = rsp[7:0];
        unique case (addr_lo)
            2'd0: b_sel = rsp[7:0];
            2'd1: b_sel = rsp[15:8];
            2'd2: b_sel = rsp[23:16];
            2'd3: b_sel = rsp[31:24];
            default: b_sel = rsp[7:0];
        endcase
        h_sel = addr_lo[1] ? rsp[31:16] : rsp[15:0];
    end

    always_comb begin
        misalign  = 1'b0;
        be        = '0;
        wdata_rep = wdata;
        rdata     = rsp;
        unique case (1'b1)
            is_b: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {{24{~usign & b_sel[7]}}, b_sel};
            end
            is_h: begin
                misalign  = addr_lo[0];
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {{16{~usign & h_sel[15]}}, h_sel};
            end
            is_w: begin
                misalign  = (addr_lo != 2'b00);
                be        = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mem_lsu.sv
// MEM-stage load/store unit: one data-memory request per access,
// pipeline stall until completion, formatted load data in DONE.
module mips_mem_lsu
    import mips_mem_lsu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lsu_valid,
    input  logic                       lsu_load,
    input  logic                       lsu_store,
    input  logic [1:0]                 lsu_size,
    input  logic                       lsu_usign,
    input  logic [MIPS_DATA_WIDTH-1:0] lsu_addr,
    input  logic [MIPS_DATA_WIDTH-1:0] lsu_wdata,
    output logic                       lsu_stall,
    output logic                       lsu_misalign,
    output logic [MIPS_DATA_WIDTH-1:0] lsu_rdata,
    output logic                       lsu_rdata_valid,
    output logic                       dmem_req_valid,
    input  logic                       dmem_req_ready,
    output logic [MIPS_DATA_WIDTH-1:0] dmem_req_addr,
    output logic                       dmem_req_we,
    output logic [MIPS_BE_WIDTH-1:0]   dmem_req_be,
    output logic [MIPS_DATA_WIDTH-1:0] dmem_req_wdata,
    input  logic                       dmem_rsp_valid,
    input  logic [MIPS_DATA_WIDTH-1:0] dmem_rsp_data
);

    logic [1:0]                 state;
    logic [MIPS_DATA_WIDTH-1:0] cap_addr;
    logic [MIPS_BE_WIDTH-1:0]   cap_be;
    logic [MIPS_DATA_WIDTH-1:0] cap_wdata;
    logic                       cap_we;
    logic [1:0]                 cap_size;
    logic                       cap_usign;
    logic [1:0]                 cap_lo;

    logic                       st_misalign;
    logic [MIPS_BE_WIDTH-1:0]   st_be;
    logic [MIPS_DATA_WIDTH-1:0] st_wdata;
    logic [MIPS_DATA_WIDTH-1:0] st_rdata_unused;
    logic                       ld_misalign_unused;
    logic [MIPS_BE_WIDTH-1:0]   ld_be_unused;
    logic [MIPS_DATA_WIDTH-1:0] ld_wdata_unused;
    logic [MIPS_DATA_WIDTH-1:0] ld_rdata;

    logic idle;
    logic op_one;
    logic op_both;
    logic start;

    mips_mem_lsu_align u_st_align (
        .addr_lo   (lsu_addr[1:0]),
        .size      (lsu_size),
        .usign     (lsu_usign),
        .wdata     (lsu_wdata),
        .rsp       ('0),
        .misalign  (st_misalign),
        .be        (st_be),
        .wdata_rep (st_wdata),
        .rdata     (st_rdata_unused)
    );

    mips_mem_lsu_align u_ld_align (
        .addr_lo   (cap_lo),
        .size      (cap_size),
        .usign     (cap_usign),
        .wdata     ('0),
        .rsp       (dmem_rsp_data),
        .misalign  (ld_misalign_unused),
        .be        (ld_be_unused),
        .wdata_rep (ld_wdata_unused),
        .rdata     (ld_rdata)
    );

    assign idle    = (state == LSU_IDLE);
    assign op_one  = lsu_load ^ lsu_store;
    assign op_both = lsu_load & lsu_store;
    assign start   = idle & lsu_valid & op_one & ~st_misalign;

    // Both-type decode is reported as an exception, never issued.
    assign lsu_misalign = idle & lsu_valid &
                          (op_both | (op_one & st_misalign));
    assign lsu_stall = start | (state == LSU_REQ) | (state == LSU_RESP);
    assign lsu_rdata_valid = (state == LSU_DONE) & ~cap_we;

    assign dmem_req_valid = (state == LSU_REQ);
    assign dmem_req_addr  = cap_addr;
    assign dmem_req_we    = cap_we;
    assign dmem_req_be    = cap_be;
    assign dmem_req_wdata = cap_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LSU_IDLE;
            cap_addr  <= '0;
            cap_be    <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            cap_size  <= '0;
            cap_usign <= 1'b0;
            cap_lo    <= '0;
            lsu_rdata <= '0;
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    if (start) begin
                        cap_addr  <= {lsu_addr[31:2], 2'b00};
                        cap_be    <= st_be;
                        cap_wdata <= st_wdata;
                        cap_we    <= lsu_store;
                        cap_size  <= lsu_size;
                        cap_usign <= lsu_usign;
                        cap_lo    <= lsu_addr[1:0];
                        state     <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (dmem_req_ready)
                        state <= cap_we ? LSU_DONE : LSU_RESP;
                end
                LSU_RESP: begin
                    if (dmem_rsp_valid) begin
                        lsu_rdata <= ld_rdata;
                        state     <= LSU_DONE;
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_lsu.sv
// Self-checking bench for mips_mem_lsu: directed scenarios plus
// randomized accesses against a lane-arithmetic reference model.
module tb_mips_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_load = 1'b0;
    logic        lsu_store = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic        lsu_usign = 1'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_stall;
    logic        lsu_misalign;
    logic [31:0] lsu_rdata;
    logic        lsu_rdata_valid;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_data = 32'h0;

    int errors = 0;
    int checks = 0;

    int          obs_cycles;
    int          obs_stall_cycles;
    int          obs_req_cycles;
    int          obs_rvalid_cnt;
    bit          obs_misalign;
    bit          obs_unstable;
    bit          obs_timeout;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic [31:0] obs_rdata;

    always #5 clk = ~clk;

    mips_mem_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_valid       (lsu_valid),
        .lsu_load        (lsu_load),
        .lsu_store       (lsu_store),
        .lsu_size        (lsu_size),
        .lsu_usign       (lsu_usign),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_stall       (lsu_stall),
        .lsu_misalign    (lsu_misalign),
        .lsu_rdata       (lsu_rdata),
        .lsu_rdata_valid (lsu_rdata_valid),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_be     (dmem_req_be),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_rsp_valid  (dmem_rsp_valid),
        .dmem_rsp_data   (dmem_rsp_data)
    );

    // Reference model: plain arithmetic over the access rules.
    function automatic bit ref_misalign(logic ld, logic st,
                                        logic [1:0] sz, logic [31:0] a);
        if (ld && st) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] sz, int k);
        if (sz == 2'd0) return 4'(1 << k);
        if (sz == 2'd1) return 4'(3 << k);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] sz, logic us,
                                             int k, logic [31:0] rsp);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rsp >> (8 * k)) & 32'hFF;
            if (!us && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rsp >> (16 * (k / 2))) & 32'hFFFF;
            if (!us && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rsp;
        end
        return v;
    endfunction

    // Drives one MEM-stage instruction and a memory with the given
    // ready/response latency; records what the DUT did.
    task automatic run_access(input logic ld, input logic st,
                              input logic [1:0] sz, input logic us,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rsp, input int rd,
                              input int rspd, input bit garbage);
        int  wait_cnt = 0;
        int  rsp_cnt = 0;
        bit  acc = 0;
        bit  seen = 0;
        bit  done = 0;
        obs_cycles = 0; obs_stall_cycles = 0; obs_req_cycles = 0;
        obs_rvalid_cnt = 0; obs_misalign = 0; obs_unstable = 0;
        obs_timeout = 0; obs_addr = 0; obs_be = 0; obs_wdata = 0;
        obs_we = 0; obs_rdata = 0;
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_load = ld; lsu_store = st;
        lsu_size = sz; lsu_usign = us; lsu_addr = a; lsu_wdata = wd;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (!acc) begin
                dmem_req_ready = dmem_req_valid && (wait_cnt >= rd);
                if (dmem_req_valid) wait_cnt++;
                dmem_rsp_valid = garbage && dmem_req_valid &&
                                 ($urandom_range(0, 1) == 1);
                dmem_rsp_data = ~rsp;
            end else begin
                dmem_req_ready = 1'b0;
                rsp_cnt++;
                dmem_rsp_valid = (rsp_cnt == rspd);
                dmem_rsp_data = (rsp_cnt == rspd) ? rsp : ~rsp;
            end
            @(negedge clk);
            obs_cycles++;
            if (lsu_stall) obs_stall_cycles++;
            if (lsu_misalign) obs_misalign = 1;
            if (lsu_rdata_valid) begin
                obs_rvalid_cnt++;
                obs_rdata = lsu_rdata;
            end
            if (dmem_req_valid) begin
                if (!seen) begin
                    obs_addr = dmem_req_addr; obs_be = dmem_req_be;
                    obs_wdata = dmem_req_wdata; obs_we = dmem_req_we;
                end else if (obs_addr !== dmem_req_addr ||
                             obs_be !== dmem_req_be ||
                             obs_wdata !== dmem_req_wdata ||
                             obs_we !== dmem_req_we) begin
                    obs_unstable = 1;
                end
                seen = 1;
                obs_req_cycles++;
                if (dmem_req_ready) acc = 1;
            end
            if (!lsu_stall) done = 1;
        end
        if (!done) obs_timeout = 1;
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({lsu_stall, lsu_misalign, lsu_rdata_valid, dmem_req_valid,
             dmem_req_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {lsu_stall, lsu_misalign, lsu_rdata_valid,
                      dmem_req_valid, dmem_req_we});
        end
        checks++;
        if ({lsu_rdata, dmem_req_addr, dmem_req_wdata, dmem_req_be} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h be %h want 0",
                     lsu_rdata, dmem_req_addr, dmem_req_wdata, dmem_req_be);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF,
                   32'h0, 0, 1, 1'b0);
        checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b1 ||
            obs_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_word_req: addr %h be %h we %b wdata %h want 100 f 1 deadbeef",
                     obs_addr, obs_be, obs_we, obs_wdata);
        end
        checks++;
        if (obs_stall_cycles !== 2 || obs_cycles !== 3) begin
            errors++;
            $display("FAIL store_word_timing: stall %0d cycles %0d want 2 3",
                     obs_stall_cycles, obs_cycles);
        end
        checks++;
        if (obs_rvalid_cnt !== 0) begin
            errors++;
            $display("FAIL store_word_rvalid: got %0d want 0", obs_rvalid_cnt);
        end
    endtask

    task automatic test_store_byte();
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h203, 32'h1234_56A5,
                   32'h0, 0, 1, 1'b0);
        checks++;
        if (obs_addr !== 32'h200 || obs_be !== 4'b1000 ||
            obs_wdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL store_byte_req: addr %h be %b wdata %h want 200 1000 a5a5a5a5",
                     obs_addr, obs_be, obs_wdata);
        end
    endtask

    task automatic test_load_ext();
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0,
                   32'h0000_8000, 0, 1, 1'b0);
        checks++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_rvalid_cnt !== 1) begin
            errors++;
            $display("FAIL load_byte_signed: got %h (valid %0d) want ffffff80",
                     obs_rdata, obs_rvalid_cnt);
        end
        checks++;
        if (obs_cycles !== 4 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_req: cycles %0d addr %h we %b want 4 100 0",
                     obs_cycles, obs_addr, obs_we);
        end
        run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h101, 32'h0,
                   32'h0000_8000, 0, 1, 1'b0);
        checks++;
        if (obs_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL load_byte_usign: got %h want 00000080", obs_rdata);
        end
        run_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0,
                   32'h8001_0000, 0, 1, 1'b0);
        checks++;
        if (obs_rdata !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL load_half_signed: got %h want ffff8001", obs_rdata);
        end
    endtask

    task automatic test_load_delayed();
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0,
                   32'h89AB_CDEF, 3, 3, 1'b1);
        checks++;
        if (obs_unstable !== 0 || obs_req_cycles !== 4) begin
            errors++;
            $display("FAIL load_delay_req: unstable %0d req_cycles %0d want 0 4",
                     obs_unstable, obs_req_cycles);
        end
        checks++;
        if (obs_stall_cycles !== 8 || obs_cycles !== 9) begin
            errors++;
            $display("FAIL load_delay_timing: stall %0d cycles %0d want 8 9",
                     obs_stall_cycles, obs_cycles);
        end
        checks++;
        if (obs_rvalid_cnt !== 1 || obs_rdata !== 32'h89AB_CDEF) begin
            errors++;
            $display("FAIL load_delay_data: valid %0d data %h want 1 89abcdef",
                     obs_rvalid_cnt, obs_rdata);
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  szs [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] ads [4] = '{32'h105, 32'h102, 32'h100, 32'h100};
        logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_access(1'b1 ^ (sts[i] & (i != 3)), sts[i], szs[i], 1'b0,
                       ads[i], 32'h5555_AAAA, 32'h0, 0, 1, 1'b0);
            checks++;
            if (obs_misalign !== 1 || obs_stall_cycles !== 0 ||
                obs_req_cycles !== 0 || obs_cycles !== 1) begin
                errors++;
                $display("FAIL misalign_%0d: mis %0d stall %0d req %0d cycles %0d want 1 0 0 1",
                         i, obs_misalign, obs_stall_cycles, obs_req_cycles,
                         obs_cycles);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_load = 1'b1; lsu_store = 1'b0;
        lsu_size = 2'd2; lsu_usign = 1'b0; lsu_addr = 32'h500;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: stall %b req %b want 1 0",
                     lsu_stall, dmem_req_valid);
        end
        rst = 1'b1;
        lsu_valid = 1'b0; lsu_load = 1'b0;
        #1;
        checks++;
        if ({lsu_stall, dmem_req_valid, lsu_rdata_valid} !== 3'b0 ||
            lsu_rdata !== 32'h0 || dmem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: stall %b req %b rv %b rdata %h addr %h want 0",
                     lsu_stall, dmem_req_valid, lsu_rdata_valid, lsu_rdata,
                     dmem_req_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_stall !== 1'b0 || lsu_rdata_valid !== 1'b0 ||
            lsu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_late_rsp: stall %b rv %b rdata %h want 0 0 0",
                     lsu_stall, lsu_rdata_valid, lsu_rdata);
        end
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0,
                   32'hCAFE_F00D, 0, 1, 1'b0);
        checks++;
        if (obs_rdata !== 32'hCAFE_F00D || obs_cycles !== 4) begin
            errors++;
            $display("FAIL rst_next_load: data %h cycles %0d want cafef00d 4",
                     obs_rdata, obs_cycles);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          sel = $urandom_range(0, 9);
            logic        ld = (sel == 1) || (sel >= 2 && sel < 6);
            logic        st = (sel == 1) || (sel >= 6);
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic        us = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rsp = $urandom;
            int          rd = $urandom_range(0, 3);
            int          rspd = $urandom_range(1, 3);
            int          k = int'(a % 4);
            int          want_cycles = 3 + rd + (st ? 0 : rspd);
            if (($urandom_range(0, 1) == 1) && sz != 2'd3)
                a = a & ~32'(sz == 2'd2 ? 3 : (sz == 2'd1 ? 1 : 0));
            k = int'(a % 4);
            run_access(ld, st, sz, us, a, wd, rsp, rd, rspd, 1'b1);
            checks++;
            if (!ld && !st) begin
                if (obs_cycles !== 1 || obs_misalign !== 0 ||
                    obs_req_cycles !== 0) begin
                    errors++;
                    $display("FAIL rnd%0d_nop: cycles %0d mis %0d req %0d want 1 0 0",
                             i, obs_cycles, obs_misalign, obs_req_cycles);
                end
            end else if (ref_misalign(ld, st, sz, a)) begin
                if (obs_cycles !== 1 || obs_misalign !== 1 ||
                    obs_req_cycles !== 0) begin
                    errors++;
                    $display("FAIL rnd%0d_mis: cycles %0d mis %0d req %0d want 1 1 0",
                             i, obs_cycles, obs_misalign, obs_req_cycles);
                end
            end else begin
                if (obs_addr !== (a - 32'(k)) || obs_be !== ref_be(sz, k) ||
                    obs_we !== st || obs_unstable !== 0 ||
                    (st && obs_wdata !== ref_wdata(sz, wd))) begin
                    errors++;
                    $display("FAIL rnd%0d_req: addr %h be %b we %b wdata %h unst %0d want %h %b %b %h 0",
                             i, obs_addr, obs_be, obs_we, obs_wdata,
                             obs_unstable, a - 32'(k), ref_be(sz, k), st,
                             ref_wdata(sz, wd));
                end
                checks++;
                if (obs_cycles !== want_cycles || obs_misalign !== 0 ||
                    obs_rvalid_cnt !== (st ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rnd%0d_timing: cycles %0d mis %0d rv %0d want %0d 0 %0d",
                             i, obs_cycles, obs_misalign, obs_rvalid_cnt,
                             want_cycles, st ? 0 : 1);
                end
                if (ld) begin
                    checks++;
                    if (obs_rdata !== ref_load(sz, us, k, rsp)) begin
                        errors++;
                        $display("FAIL rnd%0d_rdata: got %h want %h",
                                 i, obs_rdata, ref_load(sz, us, k, rsp));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_ext();
        test_load_delayed();
        test_misalign();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
